// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide controller: decoder bit positions,
// FSM state and operation kinds, plus a two's-complement negate helper.
package md_pkg;

  localparam int DATA_W = 32;
  localparam int DEC_W  = 54;

  localparam int DEC_DIV   = 53;
  localparam int DEC_MULTU = 48;
  localparam int DEC_MTLO  = 46;
  localparam int DEC_MTHI  = 45;
  localparam int DEC_MFLO  = 43;
  localparam int DEC_MFHI  = 42;
  localparam int DEC_DIVU  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  typedef enum logic [1:0] {
    MULTU = 2'd0,
    DIVU  = 2'd1,
    DIV   = 2'd2
  } md_op_t;

  function automatic logic [DATA_W-1:0] md_neg(input logic [DATA_W-1:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// Execute-stage bundle between the pipeline (master) and the multiply/divide
// controller (slave), including the controller's FSM state for observation.
interface md_ctrl_if;
  import md_pkg::*;

  // issue is the valid; stall is the inverse of ready. An instruction is taken
  // on a rising edge with issue=1, stall=0 and cancel=0; while stall is high
  // the master holds issue, decoded, rs_val and rt_val stable.
  logic              issue;
  logic [DEC_W-1:0]  decoded;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              cancel;
  logic              stall;
  logic              busy;
  logic [DATA_W-1:0] hilo_rdata;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              unsupported;
  md_state_t         dbg_state;

  modport master (
    output issue, decoded, rs_val, rt_val, cancel,
    input  stall, busy, hilo_rdata, hi, lo, unsupported, dbg_state
  );

  modport slave (
    input  issue, decoded, rs_val, rt_val, cancel,
    output stall, busy, hilo_rdata, hi, lo, unsupported, dbg_state
  );

endinterface

// File: rtl/md_iter_core.sv
// One iteration of the shared datapath: shift-add multiply step or restoring
// divide step on {upper, lower}; purely combinational.
module md_iter_core (
  input  logic        is_mul,
  input  logic [31:0] upper,
  input  logic [31:0] lower,
  input  logic [31:0] operand,
  output logic [31:0] upper_nxt,
  output logic [31:0] lower_nxt
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic        ge;

  always_comb begin
    sum       = {1'b0, upper} + (lower[0] ? {1'b0, operand} : 33'd0);
    shifted   = {upper, lower[31]};
    ge        = (shifted >= {1'b0, operand});
    upper_nxt = shifted[31:0];
    lower_nxt = {lower[30:0], 1'b0};
    if (is_mul) begin
      upper_nxt = sum[32:1];
      lower_nxt = {sum[0], lower[31:1]};
    end else if (ge) begin
      // The true difference is below the divisor, so the low 32 bits are exact.
      upper_nxt = shifted[31:0] - operand;
      lower_nxt = {lower[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller and HI/LO owner. Signed div is built only when
// MD_SIGNED_DIV_EN is defined; otherwise div raises a one-cycle unsupported pulse.
module md_ctrl
  import md_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  md_ctrl_if.slave  bus
);

  md_state_t   state_q, state_d;
  md_op_t      op_q, op_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] upper_q, upper_d;
  logic [31:0] lower_q, lower_d;
  logic [31:0] operand_q, operand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        unsup_q, unsup_d;
`ifdef MD_SIGNED_DIV_EN
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
`endif

  logic dec_div, dec_multu, dec_mtlo, dec_mthi, dec_mflo, dec_mfhi, dec_divu;
  logic is_md, accept, stall;
  logic [31:0] step_upper, step_lower;
  logic unused_dec;

  assign dec_div   = bus.decoded[DEC_DIV];
  assign dec_multu = bus.decoded[DEC_MULTU];
  assign dec_mtlo  = bus.decoded[DEC_MTLO];
  assign dec_mthi  = bus.decoded[DEC_MTHI];
  assign dec_mflo  = bus.decoded[DEC_MFLO];
  assign dec_mfhi  = bus.decoded[DEC_MFHI];
  assign dec_divu  = bus.decoded[DEC_DIVU];
  assign unused_dec = ^{bus.decoded[52:49], bus.decoded[47], bus.decoded[44],
                        bus.decoded[41:33], bus.decoded[31:0]};

  assign is_md  = dec_multu | dec_div | dec_divu | dec_mthi | dec_mtlo | dec_mfhi | dec_mflo;
  assign stall  = bus.issue && (state_q != IDLE) && is_md;
  assign accept = bus.issue && !stall && !bus.cancel;

  md_iter_core u_core (
    .is_mul    (op_q == MULTU),
    .upper     (upper_q),
    .lower     (lower_q),
    .operand   (operand_q),
    .upper_nxt (step_upper),
    .lower_nxt (step_lower)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    count_d   = count_q;
    upper_d   = upper_q;
    lower_d   = lower_q;
    operand_d = operand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unsup_d   = 1'b0;
`ifdef MD_SIGNED_DIV_EN
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_multu) begin
            op_d      = MULTU;
            upper_d   = '0;
            lower_d   = bus.rt_val;
            operand_d = bus.rs_val;
            count_d   = 5'd31;
            state_d   = RUN;
          end else if (dec_divu) begin
            op_d      = DIVU;
            upper_d   = '0;
            lower_d   = bus.rs_val;
            operand_d = bus.rt_val;
            count_d   = 5'd31;
            state_d   = RUN;
          end else if (dec_div) begin
`ifdef MD_SIGNED_DIV_EN
            op_d      = DIV;
            sign_a_d  = bus.rs_val[31];
            sign_b_d  = bus.rt_val[31];
            upper_d   = '0;
            lower_d   = bus.rs_val[31] ? md_neg(bus.rs_val) : bus.rs_val;
            operand_d = bus.rt_val[31] ? md_neg(bus.rt_val) : bus.rt_val;
            count_d   = 5'd31;
            state_d   = RUN;
`else
            unsup_d   = 1'b1;
`endif
          end else if (dec_mthi) begin
            hi_d = bus.rs_val;
          end else if (dec_mtlo) begin
            lo_d = bus.rs_val;
          end
        end
      end
      RUN: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          upper_d = step_upper;
          lower_d = step_lower;
          if (count_q == 5'd0) state_d = FIX;
          else                 count_d = count_q - 5'd1;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.cancel) begin
          // Both multiply {acc_hi, acc_lo} and divide {rem, quo} map onto HI/LO.
          hi_d = upper_q;
          lo_d = lower_q;
`ifdef MD_SIGNED_DIV_EN
          if (op_q == DIV) begin
            if (sign_a_q)            hi_d = md_neg(upper_q);
            if (sign_a_q ^ sign_b_q) lo_d = md_neg(lower_q);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= MULTU;
      count_q   <= '0;
      upper_q   <= '0;
      lower_q   <= '0;
      operand_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      unsup_q   <= 1'b0;
`ifdef MD_SIGNED_DIV_EN
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      count_q   <= count_d;
      upper_q   <= upper_d;
      lower_q   <= lower_d;
      operand_q <= operand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      unsup_q   <= unsup_d;
`ifdef MD_SIGNED_DIV_EN
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
`endif
    end
  end

  always_comb begin
    bus.hilo_rdata = '0;
    if (dec_mfhi)      bus.hilo_rdata = hi_q;
    else if (dec_mflo) bus.hilo_rdata = lo_q;
  end

  assign bus.stall       = stall;
  assign bus.busy        = (state_q != IDLE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.unsupported = unsup_q;
  assign bus.dbg_state   = state_q;

endmodule
